wb_queue: RTL
=============

# wb_queue

Write-back queue sitting directly upstream of the 2-read/1-write latch register file. It accepts results from the execute stage over a valid/ready handshake, buffers up to 2**SIZE_ADDR_Q entries in order, and retires at most one entry per cycle onto the register file write port (write, addrin, datain). It also forwards pending, not-yet-retired values to the two read ports, so decode never reads a stale register.

## Interface
- SIZE_ADDR_REG, 5, register address width; must match the register file.
- SIZE_REG, 8, register data width; must match the register file.
- SIZE_ADDR_Q, 2, queue pointer width; depth DEPTH = 2**SIZE_ADDR_Q.
- clk  input  1  single clock, all state updates on the rising edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
- in_valid  input  1  execute stage presents a result.
- in_ready  output  1  queue can accept; equals (count < DEPTH).
- in_addr  input  SIZE_ADDR_REG  destination register.
- in_data  input  SIZE_REG  result value.
- rf_hold  input  1  when high, no entry is retired this cycle.
- rf_write  output  1  registered; drives register file write.
- rf_addr  output  SIZE_ADDR_REG  registered; drives register file addrin.
- rf_data  output  SIZE_REG  registered; drives register file datain.
- read_A, read_B  input  SIZE_ADDR_REG  addresses decode is reading.
- fwd_hit_A, fwd_hit_B  output  1  combinational; a pending value exists for that address.
- fwd_data_A, fwd_data_B  output  SIZE_REG  combinational; youngest pending value, 0 when no hit.
- count  output  SIZE_ADDR_Q+1  number of entries in the queue, excluding the output register.

## Operation
- Storage: DEPTH-entry circular buffer {addr, data}, plus wr_ptr, rd_ptr, and count.
- Push: occurs when in_valid & in_ready. The entry is written at wr_ptr and wr_ptr advances modulo DEPTH.
- Pop: occurs when count > 0 and !rf_hold. The head entry at rd_ptr loads {rf_addr, rf_data}, rf_write is set to 1, and rd_ptr advances modulo DEPTH.
- No pop (count == 0 or rf_hold): rf_write is set to 0. rf_addr and rf_data keep their last values.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- in_ready = (count < DEPTH). A pop in the same cycle does not free a slot for a push; there is no combinational path from pop to in_ready.
- in_valid while in_ready = 0: the entry is not accepted. The producer must hold in_addr and in_data stable until it is accepted.
- Wrap-around: pointers are SIZE_ADDR_Q bits wide and roll from DEPTH-1 to 0 naturally. Full and empty are decided from count only.
- Forwarding, evaluated independently for ports A and B:
  - Candidates are all valid queue entries plus the output register when rf_write = 1.
  - Priority: the youngest queue entry (nearest wr_ptr-1) wins. The output register has the lowest priority because it is the oldest.
  - Entries currently on in_* that are not yet accepted are not candidates.
  - No match: fwd_hit = 0 and fwd_data = 0.
- Address 0 is an ordinary register; it gets no special treatment.
- Reset has priority over push and pop. It clears count, wr_ptr, rd_ptr, rf_write, rf_addr, and rf_data to 0. All pending entries are discarded.

## Timing
- Reset values: in_ready = 1, rf_write = 0, rf_addr = 0, rf_data = 0, count = 0, fwd_hit_A/B = 0, fwd_data_A/B = 0.
- Latency: an entry accepted at edge N into an empty queue is popped at edge N+1. rf_write is high from edge N+1 to edge N+2, and the register file latch captures the value during the high phase of that cycle.
- Back-to-back operation sustains one retire per cycle: rf_write stays high across consecutive pops.
- rf_* change only on the rising edge, so they are stable for the whole clk-high phase used by the register file's clk & write gating.
- Forwarding is purely combinational from queue state, output registers, and read_A/read_B, with zero cycle latency.
- Reset asserted mid-stream: at the next edge the queue is empty and rf_write = 0. In-flight values are lost by design, and no register file write occurs in the following cycle.

## Test plan
- Reset, then push {addr 3, data 0x5A} at edge 1 -> count = 1 after edge 1; rf_write = 1, rf_addr = 3, rf_data = 0x5A after edge 2; rf_write = 0 after edge 3.
- Hold rf_hold = 1 and push 4 entries (addr 1..4, data 0x11..0x44) -> count = 4, in_ready = 0, a fifth in_valid is not accepted. Release rf_hold -> writes retire in order 1, 2, 3, 4 on 4 consecutive cycles.
- Push addr 7 with 0xA0 then addr 7 with 0xB0 under rf_hold, with read_A = 7 -> fwd_hit_A = 1, fwd_data_A = 0xB0. read_B = 6 -> fwd_hit_B = 0, fwd_data_B = 0.
- Continuous push and pop for 10 entries (pointer wrap) -> count stays at 1, rf_data follows the input sequence exactly with 1-cycle lag, no entry is lost or duplicated.
- With 3 entries pending, assert reset for one edge -> count = 0, rf_write = 0, fwd_hit_A/B = 0 next cycle, and no further writes occur.
- Entry on the output register only (rf_write = 1, addr 9, data 0x3C) with read_A = read_B = 9 -> both hits = 1 with data 0x3C. The next cycle, with the queue empty, both hits = 0.

Source files
------------

// File: rtl/wb_queue.sv
// wb_queue: in-order write-back buffer in front of the latch register file.
// Retires one entry per cycle onto registered rf_* outputs and forwards
// pending (not yet written) values to the two decode read ports.
`timescale 1ns/1ps

// Forwarding lookup for one read port: youngest pending match wins.
module wb_queue_fwd #(
  parameter int AW = 5,
  parameter int DW = 8,
  parameter int QW = 2
) (
  input  logic [(1<<QW)-1:0][AW+DW-1:0] q,
  input  logic [QW-1:0]                 rd_ptr,
  input  logic [QW:0]                   count,
  input  logic                          rf_write,
  input  logic [AW-1:0]                 rf_addr,
  input  logic [DW-1:0]                 rf_data,
  input  logic [AW-1:0]                 rd_addr,
  output logic                          hit,
  output logic [DW-1:0]                 data
);
  localparam int DEPTH = 1 << QW;

  logic [QW-1:0] idx;

  // Scan oldest to youngest so later (younger) matches override earlier ones;
  // the output register is older than every queue entry, so it goes first.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    if (rf_write && rf_addr == rd_addr) begin
      hit  = 1'b1;
      data = rf_data;
    end
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + QW'(k);
      if ((QW+1)'(k) < count && q[idx][AW+DW-1:DW] == rd_addr) begin
        hit  = 1'b1;
        data = q[idx][DW-1:0];
      end
    end
  end
endmodule

module wb_queue #(
  parameter int SIZE_ADDR_REG = 5,
  parameter int SIZE_REG      = 8,
  parameter int SIZE_ADDR_Q   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SIZE_ADDR_REG-1:0] in_addr,
  input  logic [SIZE_REG-1:0]      in_data,
  input  logic                     rf_hold,
  output logic                     rf_write,
  output logic [SIZE_ADDR_REG-1:0] rf_addr,
  output logic [SIZE_REG-1:0]      rf_data,
  input  logic [SIZE_ADDR_REG-1:0] read_A,
  input  logic [SIZE_ADDR_REG-1:0] read_B,
  output logic                     fwd_hit_A,
  output logic                     fwd_hit_B,
  output logic [SIZE_REG-1:0]      fwd_data_A,
  output logic [SIZE_REG-1:0]      fwd_data_B,
  output logic [SIZE_ADDR_Q:0]     count
);
  localparam int DEPTH  = 1 << SIZE_ADDR_Q;
  localparam int NPORTS = 2;

  typedef struct packed {
    logic [SIZE_ADDR_REG-1:0] addr;
    logic [SIZE_REG-1:0]      data;
  } entry_t;

  entry_t [DEPTH-1:0]       mem;
  logic [SIZE_ADDR_Q-1:0]   wr_ptr, rd_ptr;
  logic                     push, pop;

  logic [NPORTS-1:0][SIZE_ADDR_REG-1:0] rd_addr;
  logic [NPORTS-1:0]                    fwd_hit;
  logic [NPORTS-1:0][SIZE_REG-1:0]      fwd_data;

  // Full/empty come from count alone; a same-cycle pop never frees a push slot.
  assign in_ready = (count < (SIZE_ADDR_Q+1)'(DEPTH));
  assign push     = in_valid & in_ready;
  assign pop      = (count != '0) & ~rf_hold;

  // Storage array carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (!reset && push) mem[wr_ptr] <= '{addr: in_addr, data: in_data};
  end

  // Pointers, occupancy and the registered register-file write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rf_write <= 1'b0;
      rf_addr  <= '0;
      rf_data  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rf_addr  <= mem[rd_ptr].addr;
        rf_data  <= mem[rd_ptr].data;
        rf_write <= 1'b1;
        rd_ptr   <= rd_ptr + 1'b1;
      end else begin
        rf_write <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_addr = {read_B, read_A};

  for (genvar p = 0; p < NPORTS; p++) begin : g_fwd
    wb_queue_fwd #(.AW(SIZE_ADDR_REG), .DW(SIZE_REG), .QW(SIZE_ADDR_Q)) u_fwd (
      .q        (mem),
      .rd_ptr   (rd_ptr),
      .count    (count),
      .rf_write (rf_write),
      .rf_addr  (rf_addr),
      .rf_data  (rf_data),
      .rd_addr  (rd_addr[p]),
      .hit      (fwd_hit[p]),
      .data     (fwd_data[p])
    );
  end

  assign fwd_hit_A  = fwd_hit[0];
  assign fwd_hit_B  = fwd_hit[1];
  assign fwd_data_A = fwd_data[0];
  assign fwd_data_B = fwd_data[1];
endmodule
